// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encodings, default parameters and one-hot helper for the scanning selector
package mux_pkg;
    localparam logic MODE_MANUAL  = 1'b0;
    localparam logic MODE_SCAN    = 1'b1;
    localparam int   DEF_WIDTH    = 4;
    localparam int   DEF_N        = 4;
    localparam int   DEF_PRESCALE = 1000;
    localparam int   MAX_N        = 16;

    function automatic logic [MAX_N-1:0] onehot(input logic [3:0] idx, input int n);
        return (int'(idx) < n) ? (MAX_N'(1) << idx) : '0;
    endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler that flags the last cycle of each PRESCALE-cycle scan dwell
module tick_gen import mux_pkg::*; #(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic CLK_i,
    input  logic RST_N_i,
    input  logic EN_i,
    input  logic CLR_i,
    output logic TICK_o
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    logic [CW-1:0] cnt;
    assign TICK_o = EN_i & ~CLR_i & (cnt == LAST);
    // count enabled cycles, wrapping at the terminal count; clear has priority
    always_ff @(posedge CLK_i or negedge RST_N_i)
        if (!RST_N_i) cnt <= '0;
        else if (CLR_i) cnt <= '0;
        else if (EN_i) cnt <= TICK_o ? '0 : cnt + 1'b1;
endmodule

// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: registered N-to-1 selector with manual select and prescaled scan modes
module mux_nx1_scan import mux_pkg::*; #(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int N        = DEF_N,
    parameter int SEL_W    = $clog2(N),
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic               CLK_i,
    input  logic               RST_N_i,
    input  logic [N*WIDTH-1:0] F_i,
    input  logic [SEL_W-1:0]   SEL_i,
    input  logic               MODE_i,
    input  logic               EN_i,
    output logic [WIDTH-1:0]   F_o,
    output logic [SEL_W-1:0]   SEL_o,
    output logic [N-1:0]       ONEHOT_o,
    output logic               TICK_o
);
    logic             mode_q;
    logic             scan;
    logic             entry;
    logic             tick;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] nidx;
    logic [SEL_W-1:0] pick;
    logic [WIDTH-1:0] dat;
    logic [MAX_N-1:0] oh;

    assign scan  = MODE_i == MODE_SCAN;
    assign entry = scan & (mode_q == MODE_MANUAL);

    tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .CLK_i   (CLK_i),
        .RST_N_i (RST_N_i),
        .EN_i    (EN_i & scan),
        .CLR_i   (EN_i & (~scan | entry)),
        .TICK_o  (tick)
    );

    // next scan index and the channel it (or the manual select) points at
    always_comb begin
        nidx = entry ? '0 : !tick ? idx : (idx == SEL_W'(N - 1)) ? '0 : idx + 1'b1;
        pick = scan ? nidx : SEL_i;
        oh   = onehot(4'(pick), N);
        dat  = '0;
        for (int k = 0; k < N; k++) if (pick == SEL_W'(k)) dat = F_i[k*WIDTH +: WIDTH];
    end

    // mode edge register, scan index and output registers; everything holds while disabled
    always_ff @(posedge CLK_i or negedge RST_N_i)
        if (!RST_N_i) begin
            mode_q   <= MODE_MANUAL;
            idx      <= '0;
            F_o      <= '0;
            SEL_o    <= '0;
            ONEHOT_o <= '0;
            TICK_o   <= 1'b0;
        end else begin
            TICK_o <= tick;
            if (EN_i) begin
                mode_q   <= MODE_i;
                idx      <= nidx;
                F_o      <= dat;
                SEL_o    <= pick;
                ONEHOT_o <= oh[N-1:0];
            end
        end
endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb_mux_nx1_scan: scoreboard bench for the scanning selector (N=4/P=4 and N=3/P=1 instances)
module tb_mux_nx1_scan;
    typedef struct packed {logic [3:0] f; logic [1:0] sel; logic [3:0] oh; logic tick;} o4_t;
    typedef struct packed {logic [3:0] f; logic [1:0] sel; logic [2:0] oh; logic tick;} o3_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        en;
    logic [15:0] f4;
    logic [1:0]  sel4;
    logic [11:0] f3;
    logic [1:0]  sel3;
    logic [3:0]  fo4;
    logic [1:0]  so4;
    logic [3:0]  oh4;
    logic        tk4;
    logic [3:0]  fo3;
    logic [1:0]  so3;
    logic [2:0]  oh3;
    logic        tk3;
    o4_t         got4;
    o3_t         got3;
    o4_t         e4;
    o3_t         e3;
    o4_t         q4[$];
    o3_t         q3[$];
    int          checks = 0;
    int          failures = 0;

    assign got4 = {fo4, so4, oh4, tk4};
    assign got3 = {fo3, so3, oh3, tk3};

    always #5 clk = ~clk;

    mux_nx1_scan #(.WIDTH(4), .N(4), .PRESCALE(4)) dut4 (
        .CLK_i(clk), .RST_N_i(rst_n), .F_i(f4), .SEL_i(sel4), .MODE_i(mode), .EN_i(en),
        .F_o(fo4), .SEL_o(so4), .ONEHOT_o(oh4), .TICK_o(tk4)
    );

    mux_nx1_scan #(.WIDTH(4), .N(3), .PRESCALE(1)) dut3 (
        .CLK_i(clk), .RST_N_i(rst_n), .F_i(f3), .SEL_i(sel3), .MODE_i(mode), .EN_i(en),
        .F_o(fo3), .SEL_o(so3), .ONEHOT_o(oh3), .TICK_o(tk3)
    );

    // expected N=4/P=4 outputs c edges after the scan-entry edge
    function automatic o4_t scan4(input int c);
        int s;
        s = (c / 4) % 4;
        return '{f: f4[s*4 +: 4], sel: 2'(s), oh: 4'(1 << s), tick: 1'(c > 0 && c % 4 == 0)};
    endfunction

    // expected N=3/P=1 outputs c edges after the scan-entry edge
    function automatic o3_t scan3(input int c);
        int s;
        s = c % 3;
        return '{f: f3[s*4 +: 4], sel: 2'(s), oh: 3'(1 << s), tick: 1'(c > 0)};
    endfunction

    task automatic enter_scan();
        mode = 1'b0;
        @(posedge clk); #1;
        mode = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; mode = 1'b0;
        f4 = 16'hDCBA; sel4 = 2'd2; f3 = 12'h321; sel3 = 2'd0;
        #12;
        q4.push_back('0);
        q3.push_back('0);
        e4 = q4.pop_front(); checks++;
        if (got4 !== e4) begin failures++; $display("FAIL reset4 got=%h exp=%h", got4, e4); end
        e3 = q3.pop_front(); checks++;
        if (got3 !== e3) begin failures++; $display("FAIL reset3 got=%h exp=%h", got3, e3); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_manual();
        mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel4 = 2'(s);
            sel3 = 2'(s);
            q4.push_back('{f: f4[s*4 +: 4], sel: 2'(s), oh: 4'(1 << s), tick: 1'b0});
            q3.push_back('{f: (s < 3) ? f3[s*4 +: 4] : 4'h0, sel: 2'(s), oh: (s < 3) ? 3'(1 << s) : 3'b000, tick: 1'b0});
            @(posedge clk); #1;
            e4 = q4.pop_front(); checks++;
            if (got4 !== e4) begin failures++; $display("FAIL manual4 sel=%0d got=%h exp=%h", s, got4, e4); end
            e3 = q3.pop_front(); checks++;
            if (got3 !== e3) begin failures++; $display("FAIL manual3 sel=%0d got=%h exp=%h", s, got3, e3); end
        end
    endtask

    task automatic test_scan();
        enter_scan();
        for (int c = 0; c <= 16; c++) begin
            if (c == 5) f4[7:4] = 4'h7;
            q4.push_back(scan4(c));
            @(posedge clk); #1;
            e4 = q4.pop_front(); checks++;
            if (got4 !== e4) begin failures++; $display("FAIL scan c=%0d got=%h exp=%h", c, got4, e4); end
        end
        f4 = 16'hDCBA;
    endtask

    task automatic test_freeze();
        o4_t held;
        enter_scan();
        for (int c = 0; c <= 5; c++) begin
            q4.push_back(scan4(c));
            @(posedge clk); #1;
            e4 = q4.pop_front(); checks++;
            if (got4 !== e4) begin failures++; $display("FAIL freeze_pre c=%0d got=%h exp=%h", c, got4, e4); end
        end
        held = scan4(5);
        en = 1'b0;
        f4[7:4] = 4'h9;
        for (int i = 0; i < 10; i++) begin
            q4.push_back(held);
            @(posedge clk); #1;
            e4 = q4.pop_front(); checks++;
            if (got4 !== e4) begin failures++; $display("FAIL freeze_hold i=%0d got=%h exp=%h", i, got4, e4); end
        end
        en = 1'b1;
        for (int c = 6; c <= 12; c++) begin
            q4.push_back(scan4(c));
            @(posedge clk); #1;
            e4 = q4.pop_front(); checks++;
            if (got4 !== e4) begin failures++; $display("FAIL freeze_post c=%0d got=%h exp=%h", c, got4, e4); end
        end
        f4 = 16'hDCBA;
    endtask

    task automatic test_back_to_back();
        enter_scan();
        for (int c = 0; c <= 6; c++) begin
            q4.push_back(scan4(c));
            @(posedge clk); #1;
            e4 = q4.pop_front(); checks++;
            if (got4 !== e4) begin failures++; $display("FAIL b2b_scan c=%0d got=%h exp=%h", c, got4, e4); end
        end
        mode = 1'b0;
        sel4 = 2'd3;
        q4.push_back('{f: 4'hD, sel: 2'd3, oh: 4'b1000, tick: 1'b0});
        @(posedge clk); #1;
        e4 = q4.pop_front(); checks++;
        if (got4 !== e4) begin failures++; $display("FAIL b2b_manual got=%h exp=%h", got4, e4); end
        mode = 1'b1;
        for (int c = 0; c <= 8; c++) begin
            q4.push_back(scan4(c));
            @(posedge clk); #1;
            e4 = q4.pop_front(); checks++;
            if (got4 !== e4) begin failures++; $display("FAIL b2b_rescan c=%0d got=%h exp=%h", c, got4, e4); end
        end
    endtask

    task automatic test_async_reset();
        enter_scan();
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        q4.push_back('0);
        q3.push_back('0);
        e4 = q4.pop_front(); checks++;
        if (got4 !== e4) begin failures++; $display("FAIL areset4 got=%h exp=%h", got4, e4); end
        e3 = q3.pop_front(); checks++;
        if (got3 !== e3) begin failures++; $display("FAIL areset3 got=%h exp=%h", got3, e3); end
        mode = 1'b0;
        sel4 = 2'd1;
        @(negedge clk) rst_n = 1'b1;
        q4.push_back('{f: 4'hB, sel: 2'd1, oh: 4'b0010, tick: 1'b0});
        @(posedge clk); #1;
        e4 = q4.pop_front(); checks++;
        if (got4 !== e4) begin failures++; $display("FAIL areset_manual got=%h exp=%h", got4, e4); end
        mode = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            q4.push_back(scan4(c));
            @(posedge clk); #1;
            e4 = q4.pop_front(); checks++;
            if (got4 !== e4) begin failures++; $display("FAIL areset_rescan c=%0d got=%h exp=%h", c, got4, e4); end
        end
    endtask

    task automatic test_prescale1();
        enter_scan();
        for (int c = 0; c <= 7; c++) begin
            q3.push_back(scan3(c));
            @(posedge clk); #1;
            e3 = q3.pop_front(); checks++;
            if (got3 !== e3) begin failures++; $display("FAIL prescale1 c=%0d got=%h exp=%h", c, got3, e3); end
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_scan();
        test_freeze();
        test_back_to_back();
        test_async_reset();
        test_prescale1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mux_nx1_scan.md
# mux_nx1_scan

Parametrised, registered N-to-1 selector, the successor of the fixed 4-channel 4-bit combinational mux. It has two modes. In manual mode it forwards the channel picked by `SEL_i`. In scan mode it cycles through all channels on an internal prescaled tick, so it can drive multiplexed 7-segment digits and LED banks in the game's display path. It also produces the current channel index, a one-hot channel strobe and a channel-change pulse for the display driver.

## Interface
Parameters:
- `WIDTH`, default 4: data width per channel.
- `N`, default 4: channel count; legal range 2..16.
- `SEL_W`, default `$clog2(N)`: select/index width; derived, not overridden.
- `PRESCALE`, default 1000: clock cycles per scan step; legal range ≥ 1.

Ports:
- `CLK_i`, in, 1: system clock, rising edge.
- `RST_N_i`, in, 1: reset, asynchronous, active-low.
- `F_i`, in, N*WIDTH: packed channel data; channel k is `F_i[k*WIDTH +: WIDTH]`.
- `SEL_i`, in, SEL_W: manual channel select.
- `MODE_i`, in, 1: 0 = manual, 1 = scan.
- `EN_i`, in, 1: 1 = run; 0 = freeze all state and outputs.
- `F_o`, out, WIDTH: registered selected data.
- `SEL_o`, out, SEL_W: channel index that `F_o` currently reflects.
- `ONEHOT_o`, out, N: one-hot of `SEL_o`; all zeros when no valid channel is selected.
- `TICK_o`, out, 1: single-cycle pulse when scan mode advances the channel.

## Operation
- Reset (asynchronous assert, synchronous release) sets:
  - `F_o` = 0, `SEL_o` = 0, `ONEHOT_o` = 0, `TICK_o` = 0.
  - Prescaler counter = 0, scan index = 0, mode register = manual.
- Manual mode (`MODE_i`=0, `EN_i`=1):
  - Each cycle: `SEL_o` ← `SEL_i`, `F_o` ← channel `SEL_i`, `ONEHOT_o` ← `1<<SEL_i`.
  - Out-of-range select (`SEL_i` ≥ N, possible when N is not a power of 2): `F_o` ← 0, `ONEHOT_o` ← 0, `SEL_o` ← `SEL_i`.
  - Prescaler is held at 0. `TICK_o` = 0.
- Scan mode (`MODE_i`=1, `EN_i`=1):
  - The prescaler counts 0..PRESCALE-1.
  - At terminal count: prescaler wraps to 0, scan index advances (N-1 wraps to 0), `TICK_o` pulses for 1 cycle.
  - Every cycle: `F_o` ← channel[scan index], `SEL_o` ← scan index, `ONEHOT_o` ← `1<<scan index`.
  - `SEL_i` is ignored.
  - `F_i` changes are tracked every cycle, not only at tick.
- Mode entry:
  - A registered copy of `MODE_i` detects transitions.
  - Manual→scan clears the prescaler and scan index, so scan starts at channel 0 with a full PRESCALE dwell.
  - Scan→manual takes effect on the next cycle with no `TICK_o`.
- Freeze (`EN_i`=0): prescaler, scan index, `F_o`, `SEL_o`, `ONEHOT_o` hold. `TICK_o` = 0. A mode change while frozen is applied at the first enabled cycle.
- `PRESCALE`=1: the index advances every enabled cycle and `TICK_o` stays high continuously.

## Timing
- Latency is 1 cycle from `F_i`/`SEL_i` at edge t to `F_o`/`SEL_o`/`ONEHOT_o` after edge t+1.
- All outputs are registered; there is no combinational input-to-output path.
- `TICK_o` is asserted in the same cycle that `SEL_o` first shows the new index.
- Scan dwell per channel is exactly PRESCALE enabled cycles; a full rotation is N*PRESCALE cycles.
- After manual→scan is sampled at edge t, `SEL_o` = 0 from t+1 and the first `TICK_o` comes at t+PRESCALE.
- Asserting reset mid-scan forces all outputs to reset values immediately. Scan does not resume until `MODE_i`=1 is seen again after release.

## Structure
- Package `mux_pkg`:
  - `MODE_MANUAL`=1'b0, `MODE_SCAN`=1'b1.
  - Default parameter constants.
  - `function onehot(idx, n)`.
- Sub-module `tick_gen`:
  - Parameter `PRESCALE`.
  - Ports: `CLK_i`, `RST_N_i`, `EN_i`, `CLR_i`, `TICK_o`.
  - Prescaler counter of width `$clog2(PRESCALE)` (min 1), instantiated once.
- Top level holds the scan index counter, mode edge register and output registers.

## Test plan
- Reset, then manual mode with N=4, WIDTH=4, F = {D,C,B,A}, `SEL_i`=2 → one cycle later `F_o`=0xC, `SEL_o`=2, `ONEHOT_o`=0100, `TICK_o`=0.
- N=3, `SEL_i`=3 → `F_o`=0, `ONEHOT_o`=000.
- Scan with PRESCALE=4, N=4:
  - Expect `SEL_o` sequence 0,1,2,3,0 with 4-cycle dwell.
  - Expect `TICK_o` on cycles 4, 8, 12, 16 after entry.
  - Expect `F_o` to follow channel data, including a mid-dwell change to `F_i` channel 1 showing up 1 cycle later.
- Scan, drop `EN_i` for 10 cycles mid-dwell → outputs and index hold, no `TICK_o`; the remaining dwell completes after re-enable.
- Scan→manual→scan → on re-entry `SEL_o`=0 and the first `TICK_o` comes after exactly PRESCALE cycles.
- Assert `RST_N_i` asynchronously between clock edges during scan → `F_o`, `SEL_o`, `ONEHOT_o` are 0 immediately; the block stays in manual after release.
